falafel_req_arbiter: RTL and testbench

Shares one falafel allocator core between NUM_REQ independent requesters, each issuing alloc or free commands. It performs round-robin arbitration, latches the winning command, and drives the core's single request handshake. It waits for the core's completion pulse and routes the result back to the granted requester. A watchdog converts a hung core operation into an error response, then drains the late completion.

---
 rtl/falafel_req_arbiter.sv | 142 ++++++++++++++
 tb/tb_falafel_req_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_req_arbiter.sv
// Round-robin front end that shares one falafel allocator core between NUM_REQ requesters.
// One command is in flight at a time; a watchdog turns a hung core operation into an error response.
module falafel_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_is_alloc_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_size_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_addr_o,
  output logic                      rsp_ok_o,
  output logic                      core_req_valid_o,
  input  logic                      core_ready_i,
  output logic                      core_is_alloc_o,
  output logic [DATA_W-1:0]         core_size_o,
  output logic [DATA_W-1:0]         core_addr_o,
  input  logic                      core_done_i,
  input  logic [DATA_W-1:0]         core_rsp_addr_i,
  input  logic                      core_rsp_ok_i,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESPOND, DRAIN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_q;
  logic               is_alloc_q;
  logic [DATA_W-1:0]  size_q;
  logic [DATA_W-1:0]  addr_q;
  logic [DATA_W-1:0]  rsp_addr_q;
  logic               rsp_ok_q;
  logic [WD_W-1:0]    wdog;
  logic               drain_first;
  logic               timeout_q;

  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   rr_next;
  logic [NUM_REQ-1:0] grant_oh;
  logic               rsp_fire;

  // Scan downwards so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_oh = NUM_REQ'(1) << grant_idx;
  assign rr_next  = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_q     <= '0;
      is_alloc_q  <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      rsp_addr_q  <= '0;
      rsp_ok_q    <= 1'b0;
      wdog        <= '0;
      drain_first <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            grant_q    <= grant_idx;
            is_alloc_q <= req_is_alloc_i[grant_idx];
            size_q     <= req_size_i[int'(grant_idx)*DATA_W +: DATA_W];
            addr_q     <= req_addr_i[int'(grant_idx)*DATA_W +: DATA_W];
            rr_ptr     <= rr_next;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (core_ready_i) begin
            wdog  <= '0;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (core_done_i) begin
            rsp_addr_q <= is_alloc_q ? core_rsp_addr_i : '0;
            rsp_ok_q   <= core_rsp_ok_i;
            state      <= RESPOND;
          end else if (wdog >= WD_LAST) begin
            rsp_addr_q  <= '0;
            rsp_ok_q    <= 1'b0;
            timeout_q   <= 1'b1;
            drain_first <= 1'b1;
            state       <= DRAIN;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
        RESPOND: state <= IDLE;
        DRAIN: begin
          // The error pulse has gone out; the late completion is swallowed here.
          drain_first <= 1'b0;
          if (core_done_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_fire         = (state == RESPOND) || ((state == DRAIN) && drain_first);
  assign req_ready_o      = ((state == IDLE) && grant_vld && rst_ni) ? grant_oh : '0;
  assign rsp_valid_o      = rsp_fire ? (NUM_REQ'(1) << grant_q) : '0;
  assign rsp_addr_o       = rsp_fire ? rsp_addr_q : '0;
  assign rsp_ok_o         = rsp_fire && rsp_ok_q;
  assign core_req_valid_o = (state == ISSUE);
  assign core_is_alloc_o  = is_alloc_q;
  assign core_size_o      = size_q;
  assign core_addr_o      = addr_q;
  assign busy_o           = (state != IDLE);
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Randomized bench for falafel_req_arbiter: transaction-level model of grant order,
// latched payload, response timing and the sticky timeout flag.
module tb_falafel_req_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 64;
  localparam int TIMEOUT_CYC = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_is_alloc;
  logic [NUM_REQ*DATA_W-1:0] req_size;
  logic [NUM_REQ*DATA_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_addr;
  logic                      rsp_ok;
  logic                      core_req_valid;
  logic                      core_ready;
  logic                      core_is_alloc;
  logic [DATA_W-1:0]         core_size;
  logic [DATA_W-1:0]         core_addr;
  logic                      core_done;
  logic [DATA_W-1:0]         core_rsp_addr;
  logic                      core_rsp_ok;
  logic                      busy;
  logic                      timeout;

  falafel_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_alloc_i(req_is_alloc),
    .req_size_i(req_size), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_addr_o(rsp_addr), .rsp_ok_o(rsp_ok),
    .core_req_valid_o(core_req_valid), .core_ready_i(core_ready),
    .core_is_alloc_o(core_is_alloc), .core_size_o(core_size), .core_addr_o(core_addr),
    .core_done_i(core_done), .core_rsp_addr_i(core_rsp_addr), .core_rsp_ok_i(core_rsp_ok),
    .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int rr_m = 0;
  logic timeout_m = 1'b0;
  logic [DATA_W-1:0] size_t[NUM_REQ];
  logic [DATA_W-1:0] addr_t[NUM_REQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int arb(input int ptr, input logic [NUM_REQ-1:0] m);
    for (int k = 0; k < NUM_REQ; k++)
      if (m[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] oh(input int g);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_req();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_size[k*DATA_W +: DATA_W] = size_t[k];
      req_addr[k*DATA_W +: DATA_W] = addr_t[k];
    end
  endtask

  task automatic scramble_req();
    for (int k = 0; k < NUM_REQ; k++) begin
      size_t[k] = rnd64();
      addr_t[k] = rnd64();
    end
    req_valid    = NUM_REQ'($urandom);
    req_is_alloc = NUM_REQ'($urandom);
    drive_req();
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full command: done_dly < 0 means the core never answers in time.
  task automatic do_txn(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] alloc,
                        input int rdy_dly, input int done_dly,
                        input logic [63:0] raddr, input logic rok, input int exp_g);
    int g;
    int nwait;
    int dd;
    logic e_alloc;
    logic [DATA_W-1:0] e_size, e_addr;
    g = arb(rr_m, mask);
    req_valid = mask;
    req_is_alloc = alloc;
    drive_req();
    core_done = 1'($urandom);
    core_rsp_addr = rnd64();
    core_rsp_ok = 1'($urandom);
    #1;
    chk("idle_busy", busy, 0);
    chk("grant", req_ready, oh(g));
    if (exp_g >= 0) chk("grant_order", req_ready, oh(exp_g));
    chk("idle_stray_done", rsp_valid, 0);
    e_alloc = alloc[g];
    e_size = size_t[g];
    e_addr = addr_t[g];
    rr_m = (g + 1) % NUM_REQ;
    step();
    scramble_req();
    for (int c = 0; c <= rdy_dly; c++) begin
      core_ready = (c == rdy_dly);
      core_done = 1'($urandom);
      #1;
      chk("issue_valid", core_req_valid, 1);
      chk("issue_alloc", core_is_alloc, e_alloc);
      chk("issue_size", core_size, e_size);
      chk("issue_addr", core_addr, e_addr);
      chk("issue_ready0", req_ready, 0);
      chk("issue_busy", busy, 1);
      chk("issue_rsp0", rsp_valid, 0);
      step();
    end
    core_ready = 1'b0;
    core_done = 1'b0;
    nwait = (done_dly < 0) ? TIMEOUT_CYC : done_dly + 1;
    for (int c = 0; c < nwait; c++) begin
      core_done = (c == done_dly);
      core_rsp_addr = (c == done_dly) ? raddr : rnd64();
      core_rsp_ok = (c == done_dly) ? rok : 1'($urandom);
      #1;
      chk("wait_core_valid0", core_req_valid, 0);
      chk("wait_rsp0", rsp_valid, 0);
      chk("wait_busy", busy, 1);
      step();
    end
    core_done = 1'b0;
    if (done_dly >= 0) begin
      #1;
      chk("rsp_valid", rsp_valid, oh(g));
      chk("rsp_addr", rsp_addr, e_alloc ? raddr : 64'd0);
      chk("rsp_ok", rsp_ok, rok);
      chk("rsp_timeout", timeout, timeout_m);
      step();
      #1;
      chk("post_rsp_valid0", rsp_valid, 0);
      chk("post_rsp_addr0", rsp_addr, 0);
      chk("post_rsp_busy0", busy, 0);
    end else begin
      timeout_m = 1'b1;
      #1;
      chk("to_rsp_valid", rsp_valid, oh(g));
      chk("to_rsp_ok", rsp_ok, 0);
      chk("to_rsp_addr", rsp_addr, 0);
      chk("to_flag", timeout, 1);
      step();
      dd = $urandom_range(1, 4);
      for (int c = 0; c < dd; c++) begin
        #1;
        chk("drain_rsp0", rsp_valid, 0);
        chk("drain_busy", busy, 1);
        step();
      end
      core_done = 1'b1;
      core_rsp_addr = rnd64();
      core_rsp_ok = 1'b1;
      #1;
      chk("drain_done_rsp0", rsp_valid, 0);
      step();
      core_done = 1'b0;
      #1;
      chk("drain_exit_rsp0", rsp_valid, 0);
      chk("drain_exit_busy", busy, 0);
      chk("drain_exit_flag", timeout, 1);
    end
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int dsel;
    int ddly;
    rst_n = 1'b0;
    req_valid = '0;
    req_is_alloc = '0;
    req_size = '0;
    req_addr = '0;
    core_ready = 1'b0;
    core_done = 1'b0;
    core_rsp_addr = '0;
    core_rsp_ok = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_core_valid", core_req_valid, 0);
    chk("rst_core_size", core_size, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: everyone requesting continuously.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin size_t[k] = rnd64(); addr_t[k] = rnd64(); end
      do_txn('1, 4'b1111, 0, 1, rnd64(), 1'b1, exp_order[i]);
    end

    // Single alloc from requester 0.
    size_t[0] = 64'h40;
    do_txn(4'b0001, 4'b0001, 0, 4, 64'h100, 1'b1, 0);

    // Free from requester 2: returned address must be masked to zero.
    addr_t[2] = 64'h200;
    do_txn(4'b0100, 4'b0000, 0, 2, 64'hDEAD, 1'b1, 2);

    // Long core backpressure.
    do_txn(4'b1000, 4'b1000, 20, 0, 64'h300, 1'b0, 3);

    // Timeout, then done on the very last watchdog cycle.
    do_txn(4'b0010, 4'b0010, 0, -1, 64'h0, 1'b0, 1);
    do_txn(4'b0001, 4'b0001, 1, TIMEOUT_CYC - 1, 64'h480, 1'b1, 0);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < NUM_REQ; k++) begin size_t[k] = rnd64(); addr_t[k] = rnd64(); end
      dsel = $urandom_range(0, 9);
      ddly = (dsel == 0) ? -1 : (dsel == 1) ? TIMEOUT_CYC - 1 : $urandom_range(0, 6);
      do_txn(NUM_REQ'($urandom_range(1, 15)), NUM_REQ'($urandom), $urandom_range(0, 3),
             ddly, rnd64(), 1'($urandom), -1);
    end

    // Asynchronous reset while waiting on the core.
    for (int k = 0; k < NUM_REQ; k++) begin size_t[k] = rnd64(); addr_t[k] = rnd64(); end
    req_valid = '1;
    req_is_alloc = '1;
    drive_req();
    step();
    req_valid = '0;
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_core_valid", core_req_valid, 0);
    chk("arst_rsp", rsp_valid, 0);
    chk("arst_rsp_ok", rsp_ok, 0);
    chk("arst_core_size", core_size, 0);
    chk("arst_core_alloc", core_is_alloc, 0);
    chk("arst_timeout", timeout, 0);
    step();
    rst_n = 1'b1;
    rr_m = 0;
    timeout_m = 1'b0;
    step();
    do_txn('1, 4'b0000, 0, 0, 64'h1, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
